// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide sequencing controller.
// Results are computed when an op is accepted and then held for a fixed number
// of cycles. This models the latency of a multi-cycle multiplier/divider.
// The architectural HI/LO registers only update when the countdown ends.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_stall
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_wr;

    logic        is_md_op;
    logic        is_mult;
    logic [63:0] prod_s, prod_u;
    logic [31:0] dvsr;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    assign is_md_op = (op >= 3'd1) && (op <= 3'd4);
    assign is_mult  = (op == 3'd1) || (op == 3'd2);

    // A zero divisor is replaced by 1 so the divider never produces X.
    // The result is discarded anyway because res_wr is cleared.
    assign dvsr   = (rt_val == 32'd0) ? 32'd1 : rt_val;
    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Result select for the op being accepted this cycle.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (op)
            3'd1: {res_hi, res_lo} = prod_s;
            3'd2: {res_hi, res_lo} = prod_u;
            3'd3: begin
                // The most-negative value divided by -1 overflows the native
                // divide, so that case is pinned explicitly.
                if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(rs_val) / $signed(dvsr);
                    res_hi = $signed(rs_val) % $signed(dvsr);
                end
                res_wr = (rt_val != 32'd0);
            end
            3'd4: begin
                res_lo = rs_val / dvsr;
                res_hi = rs_val % dvsr;
                res_wr = (rt_val != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    // Stall in the same cycle the op arrives, because busy is not registered
    // high until the following edge.
    assign md_stall = md_use_d & (busy | (start & is_md_op));

    // IDLE/RUN sequencer. HI/LO are committed at the end of the countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_md_op) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                            cnt     <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                            state   <= RUN;
                            busy    <= 1'b1;
                        end else if (op == 3'd5) begin
                            hi <= rs_val;
                        end else if (op == 3'd6) begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= 4'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed test for mdu_ctrl. The stimulus pushes the expected HI/LO and busy
// length of every multi-cycle op into a queue. A monitor pops one entry each
// time busy falls and compares it.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        md_use_d = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, md_stall;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
        .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op for a single cycle. Inputs change 1 time unit after the rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        rs_val = 32'h5A5A_5A5A; rt_val = 32'hA5A5_A5A5;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input int n, input string nm);
        exp_t e;
        e.hi = h; e.lo = l; e.len = n; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == 40) begin
            n_tests++; n_fail++;
            $display("FAIL %s: busy still high after 40 cycles", nm);
        end
    endtask

    // Monitor: measure the busy length and compare the results when busy falls.
    initial begin
        int   len;
        logic prev;
        exp_t e;
        len = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                len = 0; prev = 1'b0;
            end else begin
                if (busy) len++;
                else if (prev) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: got completion, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_hi"}, hi, e.hi);
                        check({e.name, "_lo"}, lo, e.lo);
                        check({e.name, "_len"}, 32'(len), 32'(e.len));
                    end
                    len = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1; reset = 1'b1;

        // Asynchronous reset in the middle of a DIV. HI is preloaded first so the clear is visible.
        issue(3'd5, 32'h55, 32'd0);
        check("mthi_pre", hi, 32'h55);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3; reset = 1'b0; #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); @(posedge clk); #1; reset = 1'b1;

        // Multiplies
        push(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult");
        issue(3'd1, 32'hFFFF_FFFF, 32'h2); wait_idle("mult");
        push(32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
        issue(3'd2, 32'hFFFF_FFFF, 32'h2); wait_idle("multu");

        // Divides
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
        issue(3'd3, 32'hFFFF_FFF9, 32'h2); wait_idle("div_neg");
        push(32'h1, 32'h3, 10, "divu");
        issue(3'd4, 32'h7, 32'h2); wait_idle("divu");
        push(32'h0, 32'h8000_0000, 10, "div_ovf");
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle("div_ovf");

        // Divide by zero leaves the preloaded HI/LO untouched.
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        push(32'h11, 32'h22, 10, "divz");
        issue(3'd4, 32'h1234, 32'h0); wait_idle("divz");

        // Stall covers the start cycle and all 5 busy cycles.
        push(32'h0, 32'd12, 5, "mult_stall");
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd4; md_use_d = 1'b1;
        @(negedge clk);
        check("stall_start", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #1; start = 1'b0; op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_busy%0d", i), {31'd0, md_stall}, 32'd1);
        end
        @(negedge clk);
        check("stall_end", {31'd0, md_stall}, 32'd0);
        md_use_d = 1'b0;

        // Without md_use_d, there is never a stall.
        push(32'h0, 32'd20, 5, "mult_nouse");
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; rs_val = 32'd4; rt_val = 32'd5;
        @(negedge clk);
        check("nostall_start", {31'd0, md_stall}, 32'd0);
        @(posedge clk); #1; start = 1'b0; op = 3'd0;
        @(negedge clk);
        check("nostall_busy", {31'd0, md_stall}, 32'd0);
        wait_idle("mult_nouse");

        // MTLO while IDLE: single cycle, HI unchanged, no busy.
        issue(3'd6, 32'hDEAD_BEEF, 32'd0);
        check("mtlo_lo", lo, 32'hDEAD_BEEF);
        check("mtlo_hi", hi, 32'h0);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // MTHI during RUN is ignored, and HI comes from the product.
        // The operands are also changed mid-run and must not affect the result.
        push(32'h0, 32'd6, 5, "mthi_in_run");
        issue(3'd1, 32'd2, 32'd3);
        issue(3'd5, 32'hCAFE_F00D, 32'd9);
        wait_idle("mthi_in_run");

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
